fetch_queue: RTL and testbench

- Dual-issue instruction queue directly downstream of the fetch stage.
- Each cycle it accepts a fetched pair of 32-bit instructions with their PC.
- It presents up to two oldest instructions, in program order, to the dual decoder.
- It back-pressures fetch via busy and is flushed on jal / jalr / conditional-jump redirects.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode-side signal bundle for the dual-issue fetch queue.
// The queue uses the slave modport; whatever drives fetch and decode uses master.
interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             flush;
    logic             in_valid;
    logic [63:0]      in_instr;
    logic [31:0]      in_pc;
    logic             busy;
    logic [1:0]       deq_cnt;
    logic             out_valid0;
    logic [31:0]      out_instr0;
    logic [31:0]      out_pc0;
    logic             out_valid1;
    logic [31:0]      out_instr1;
    logic [31:0]      out_pc1;
    logic [PTR_W:0]   count;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, deq_cnt,
        output busy, out_valid0, out_instr0, out_pc0,
        output out_valid1, out_instr1, out_pc1, count
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, deq_cnt,
        input  busy, out_valid0, out_instr0, out_pc0,
        input  out_valid1, out_instr1, out_pc1, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between fetch and decode: takes a pair per cycle,
// presents the two oldest instructions in program order, flushes on redirects.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_queue_if.slave fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [CNT_W-1:0] count_next;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc_mem    [DEPTH];

    logic             busy;
    logic             enq;
    logic [CNT_W-1:0] deq_req;
    logic [CNT_W-1:0] deq_n;
    logic [PTR_W-1:0] rd_ptr1;
    logic [PTR_W-1:0] wr_ptr1;

    // Busy is taken from the registered count, so a same-cycle drain does not free room.
    assign busy    = (count_reg >= CNT_W'(DEPTH - 1));
    assign enq     = fq.in_valid && !busy && !fq.flush;
    assign rd_ptr1 = rd_ptr_reg + PTR_W'(1);
    assign wr_ptr1 = wr_ptr_reg + PTR_W'(1);

    always_comb begin
        deq_req = fq.deq_cnt[1] ? CNT_W'(2) : {{(CNT_W-2){1'b0}}, fq.deq_cnt};
        deq_n   = (deq_req > count_reg) ? count_reg : deq_req;
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg + deq_n[PTR_W-1:0];
        wr_ptr_next = enq ? (wr_ptr_reg + PTR_W'(2)) : wr_ptr_reg;
        count_next  = count_reg + (enq ? CNT_W'(2) : CNT_W'(0)) - deq_n;
        if (fq.flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Second instruction of a pair lands at wr_ptr+1, wrapping to entry 0 at the top.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr_reg] <= fq.in_instr[31:0];
            pc_mem[wr_ptr_reg]    <= fq.in_pc;
            instr_mem[wr_ptr1]    <= fq.in_instr[63:32];
            pc_mem[wr_ptr1]       <= fq.in_pc + 32'd4;
        end
    end

    always_comb begin
        fq.busy       = busy;
        fq.count      = count_reg;
        fq.out_valid0 = (count_reg >= CNT_W'(1));
        fq.out_valid1 = (count_reg >= CNT_W'(2));
        fq.out_instr0 = '0;
        fq.out_pc0    = '0;
        fq.out_instr1 = '0;
        fq.out_pc1    = '0;
        if (fq.out_valid0) begin
            fq.out_instr0 = instr_mem[rd_ptr_reg];
            fq.out_pc0    = pc_mem[rd_ptr_reg];
        end
        if (fq.out_valid1) begin
            fq.out_instr1 = instr_mem[rd_ptr1];
            fq.out_pc1    = pc_mem[rd_ptr1];
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a FIFO-queue model is compared on every falling edge,
// with hand-computed literal checks at the interesting points.
module tb_fetch_queue;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    fetch_queue_if #(.DEPTH(DEPTH)) fq ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fq    (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an ordered queue of {instr, pc} entries.
    logic [63:0] mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mk_instr(input logic [31:0] pc);
        return {32'h2300_0000 | (pc + 32'd4), 32'h1300_0000 | pc};
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int sz;
        int n;
        bit acc;
        if (!rst_n) begin
            mq.delete();
        end else if (fq.flush) begin
            mq.delete();
        end else begin
            sz  = mq.size();
            acc = fq.in_valid && ((DEPTH - sz) >= 2);
            n   = (fq.deq_cnt == 2'd3) ? 2 : int'(fq.deq_cnt);
            if (n > sz) n = sz;
            repeat (n) void'(mq.pop_front());
            if (acc) begin
                mq.push_back({fq.in_instr[31:0], fq.in_pc});
                mq.push_back({fq.in_instr[63:32], fq.in_pc + 32'd4});
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] ei0, ep0, ei1, ep1;
        int sz;
        sz  = mq.size();
        ei0 = 0; ep0 = 0; ei1 = 0; ep1 = 0;
        if (sz >= 1) begin ei0 = mq[0][63:32]; ep0 = mq[0][31:0]; end
        if (sz >= 2) begin ei1 = mq[1][63:32]; ep1 = mq[1][31:0]; end
        chk("count",  32'(fq.count), 32'(sz));
        chk("busy",   32'(fq.busy), 32'((DEPTH - sz) < 2));
        chk("valid0", 32'(fq.out_valid0), 32'(sz >= 1));
        chk("valid1", 32'(fq.out_valid1), 32'(sz >= 2));
        chk("instr0", fq.out_instr0, ei0);
        chk("pc0",    fq.out_pc0, ep0);
        chk("instr1", fq.out_instr1, ei1);
        chk("pc1",    fq.out_pc1, ep1);
    end

    task automatic step(input logic v, input logic [31:0] pc, input logic [1:0] dq, input logic fl);
        fq.in_valid = v;
        fq.in_pc    = pc;
        fq.in_instr = mk_instr(pc);
        fq.deq_cnt  = dq;
        fq.flush    = fl;
        @(posedge clk);
        #1;
        $display("step: in_valid=%0d pc=%h deq=%0d flush=%0d -> count=%0d busy=%0d pc0=%h pc1=%h",
                 v, pc, dq, fl, fq.count, fq.busy, fq.out_pc0, fq.out_pc1);
    endtask

    initial begin
        rst_n       = 1'b0;
        fq.flush    = 1'b0;
        fq.in_valid = 1'b0;
        fq.in_instr = '0;
        fq.in_pc    = '0;
        fq.deq_cnt  = 2'd0;
        #22;
        rst_n = 1'b1;
        chk("reset_count", 32'(fq.count), 32'd0);
        chk("reset_busy", 32'(fq.busy), 32'd0);
        chk("reset_pc0", fq.out_pc0, 32'd0);

        // Fill
        step(1, 32'h00, 0, 0);
        step(1, 32'h08, 0, 0);
        step(1, 32'h10, 0, 0);
        chk("fill_busy6", 32'(fq.busy), 32'd0);
        step(1, 32'h18, 0, 0);
        chk("fill_count", 32'(fq.count), 32'd8);
        chk("fill_busy", 32'(fq.busy), 32'd1);
        chk("fill_pc0", fq.out_pc0, 32'h00);
        chk("fill_pc1", fq.out_pc1, 32'h04);
        step(1, 32'h20, 0, 0);
        chk("full_hold_count", 32'(fq.count), 32'd8);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc0", fq.out_pc0, 32'(i * 8));
            step(0, 32'h0, 2, 0);
            chk("drain_count", 32'(fq.count), 32'(6 - 2 * i));
        end
        chk("drain_valid0", 32'(fq.out_valid0), 32'd0);
        chk("drain_instr0", fq.out_instr0, 32'd0);

        // Odd dequeue and wrap
        step(1, 32'h100, 0, 0);
        step(1, 32'h108, 0, 0);
        step(1, 32'h110, 0, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);
        step(1, 32'h118, 0, 0);
        step(1, 32'h120, 0, 0);
        chk("wrap_count", 32'(fq.count), 32'd7);
        chk("wrap_pc0", fq.out_pc0, 32'h10C);
        chk("wrap_busy", 32'(fq.busy), 32'd1);

        // Busy at 7: input ignored while one drains
        step(1, 32'h200, 1, 0);
        chk("busy7_count", 32'(fq.count), 32'd6);
        chk("busy7_pc0", fq.out_pc0, 32'h110);
        // Simultaneous enq/deq at 6
        step(1, 32'h200, 2, 0);
        chk("simul_count", 32'(fq.count), 32'd6);
        chk("simul_busy", 32'(fq.busy), 32'd0);
        chk("simul_pc0", fq.out_pc0, 32'h118);
        step(0, 32'h0, 2, 0);
        step(0, 32'h0, 2, 0);
        chk("wrapped_pc0", fq.out_pc0, 32'h200);
        chk("wrapped_pc1", fq.out_pc1, 32'h204);

        // Over-request
        step(0, 32'h0, 1, 0);
        chk("over_pre_count", 32'(fq.count), 32'd1);
        step(0, 32'h0, 3, 0);
        chk("over_count", 32'(fq.count), 32'd0);
        step(0, 32'h0, 2, 0);
        chk("empty_count", 32'(fq.count), 32'd0);
        step(1, 32'h40, 0, 0);
        chk("after_over_pc0", fq.out_pc0, 32'h40);

        // Flush
        step(1, 32'h300, 0, 0);
        step(1, 32'h308, 0, 0);
        chk("preflush_count", 32'(fq.count), 32'd6);
        step(1, 32'h400, 2, 1);
        chk("flush_count", 32'(fq.count), 32'd0);
        chk("flush_valid0", 32'(fq.out_valid0), 32'd0);
        step(1, 32'h20, 0, 0);
        chk("postflush_pc0", fq.out_pc0, 32'h20);
        chk("postflush_pc1", fq.out_pc1, 32'h24);
        step(1, 32'h500, 0, 1);
        step(1, 32'h508, 0, 1);
        chk("held_flush_count", 32'(fq.count), 32'd0);

        // Async reset mid-run at count 5
        step(1, 32'h600, 0, 0);
        step(1, 32'h608, 0, 0);
        step(1, 32'h610, 1, 0);
        chk("prereset_count", 32'(fq.count), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_count", 32'(fq.count), 32'd0);
        chk("async_busy", 32'(fq.busy), 32'd0);
        chk("async_valid0", 32'(fq.out_valid0), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 32'h700, 0, 0);
        chk("post_reset_pc1", fq.out_pc1, 32'h704);
        step(0, 32'h0, 2, 0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
